// File: rtl/fix_tx_scheduler_pkg.sv
// Shared constants, state encoding and index helper for the FIX transmit scheduler
// and the receive-side dispatcher that reuses the round-robin picker.
package fix_pkg;

    localparam int NUM_HOSTS     = 4;
    localparam int HOST_W        = $clog2(NUM_HOSTS);
    localparam int DATA_W        = 8;
    localparam int MAX_MSG_BYTES = 1024;
    localparam int CNT_W         = 11;

    typedef enum logic {
        IDLE,
        BUSY
    } sched_state_t;

    // Host index reached by stepping 'offset' places from 'base', wrapping.
    function automatic logic [HOST_W-1:0] wrapIdx(input int base, input int offset);
        return HOST_W'((base + offset) % NUM_HOSTS);
    endfunction

endpackage

// File: rtl/fix_tx_scheduler_if.sv
// Bundle of TOE session events, per-host source streams and the shared FIFO port.
interface fix_tx_if;
    import fix_pkg::*;

    logic                        connected_i;
    logic [HOST_W-1:0]           connected_host_addr_i;
    logic                        disconnect_i;
    logic [HOST_W-1:0]           disconnect_host_num_i;
    logic [NUM_HOSTS-1:0]        src_valid_i;
    logic [NUM_HOSTS-1:0]        src_last_i;
    logic [NUM_HOSTS*DATA_W-1:0] src_data_i;
    logic [NUM_HOSTS-1:0]        src_ready_o;
    logic                        fifo_full_i;
    logic                        send_message_valid_o;
    logic [DATA_W-1:0]           message_o;
    logic                        message_last_o;
    logic [HOST_W-1:0]           tx_host_o;
    logic [NUM_HOSTS-1:0]        host_up_o;
    logic                        abort_o;

    modport slave (
        input  connected_i, connected_host_addr_i, disconnect_i, disconnect_host_num_i,
        input  src_valid_i, src_last_i, src_data_i, fifo_full_i,
        output src_ready_o, send_message_valid_o, message_o, message_last_o,
        output tx_host_o, host_up_o, abort_o
    );

    modport master (
        output connected_i, connected_host_addr_i, disconnect_i, disconnect_host_num_i,
        output src_valid_i, src_last_i, src_data_i, fifo_full_i,
        input  src_ready_o, send_message_valid_o, message_o, message_last_o,
        input  tx_host_o, host_up_o, abort_o
    );

endinterface

// File: rtl/fix_tx_scheduler_rr_picker.sv
// Combinational round-robin picker: first eligible index at or after the pointer, wrapping.
module fix_rr_picker
    import fix_pkg::*;
(
    input  logic [NUM_HOSTS-1:0] i_eligible,
    input  logic [HOST_W-1:0]    i_rrPtr,
    output logic                 o_found,
    output logic [HOST_W-1:0]    o_idx
);

    // Scan from the farthest offset down so the nearest eligible index wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int k = NUM_HOSTS - 1; k >= 0; k--) begin
            if (i_eligible[wrapIdx(int'(i_rrPtr), k)]) begin
                o_found = 1'b1;
                o_idx   = wrapIdx(int'(i_rrPtr), k);
            end
        end
    end

endmodule

// File: rtl/fix_tx_scheduler.sv
// Shares the TOE transmit FIFO between per-host session sources with message-granular
// round-robin, tracking live sessions and truncating messages on disconnect or runaway length.
module fix_tx_scheduler
    import fix_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    fix_tx_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_MSG_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    sched_state_t         r_state;
    logic [NUM_HOSTS-1:0] r_hostUp;
    logic [HOST_W-1:0]    r_rrPtr;
    logic [HOST_W-1:0]    r_grant;
    logic [CNT_W-1:0]     r_byteCnt;
    logic                 r_valid;
    logic [DATA_W-1:0]    r_data;
    logic                 r_last;
    logic [HOST_W-1:0]    r_txHost;
    logic                 r_abort;

    logic [NUM_HOSTS-1:0] w_eligible;
    logic [NUM_HOSTS-1:0] w_ready;
    logic [NUM_HOSTS-1:0] w_hostUpNext;
    logic                 w_found;
    logic [HOST_W-1:0]    w_pickIdx;
    logic                 w_xfer;
    logic                 w_srcLast;
    logic [DATA_W-1:0]    w_srcByte;
    logic                 w_watchdog;
    logic                 w_hostLost;

    assign w_eligible = bus.src_valid_i & r_hostUp;

    fix_rr_picker u_picker (
        .i_eligible (w_eligible),
        .i_rrPtr    (r_rrPtr),
        .o_found    (w_found),
        .o_idx      (w_pickIdx)
    );

    always_comb begin
        w_ready = '0;
        if (r_state == BUSY && !bus.fifo_full_i && r_hostUp[r_grant]) begin
            w_ready[r_grant] = 1'b1;
        end
    end

    assign w_xfer     = bus.src_valid_i[r_grant] & w_ready[r_grant];
    assign w_srcLast  = bus.src_last_i[r_grant];
    assign w_srcByte  = bus.src_data_i[r_grant*DATA_W +: DATA_W];
    assign w_watchdog = w_xfer && !w_srcLast && (r_byteCnt == CNT_LAST);
    assign w_hostLost = (r_state == BUSY) && !r_hostUp[r_grant];

    // Disconnect is applied after connect so it wins when both hit the same host.
    always_comb begin
        w_hostUpNext = r_hostUp;
        if (bus.connected_i) begin
            w_hostUpNext[bus.connected_host_addr_i] = 1'b1;
        end
        if (bus.disconnect_i) begin
            w_hostUpNext[bus.disconnect_host_num_i] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_hostUp  <= '0;
            r_rrPtr   <= '0;
            r_grant   <= '0;
            r_byteCnt <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_last    <= 1'b0;
            r_txHost  <= '0;
            r_abort   <= 1'b0;
        end else begin
            r_hostUp <= w_hostUpNext;
            r_valid  <= w_xfer;
            r_data   <= w_xfer ? w_srcByte : '0;
            r_last   <= w_xfer && (w_srcLast || w_watchdog);
            r_txHost <= w_xfer ? r_grant : '0;
            r_abort  <= w_hostLost || w_watchdog;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant   <= w_pickIdx;
                        r_byteCnt <= '0;
                        r_state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_hostLost) begin
                        r_state <= IDLE;
                        r_rrPtr <= wrapIdx(int'(r_grant), 1);
                    end else if (w_xfer) begin
                        if (r_byteCnt != CNT_SAT) begin
                            r_byteCnt <= r_byteCnt + 1'b1;
                        end
                        if (w_srcLast || w_watchdog) begin
                            r_state <= IDLE;
                            r_rrPtr <= wrapIdx(int'(r_grant), 1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.src_ready_o          = w_ready;
    assign bus.send_message_valid_o = r_valid;
    assign bus.message_o            = r_data;
    assign bus.message_last_o       = r_last;
    assign bus.tx_host_o            = r_txHost;
    assign bus.host_up_o            = r_hostUp;
    assign bus.abort_o              = r_abort;

endmodule

// File: doc/fix_tx_scheduler.md
# fix_tx_scheduler

Shares the single TOE transmit FIFO port (`send_message_valid_o` / `message_o` path of the FIX engine) between up to four per-host session sources. It tracks which hosts are connected from TOE connect/disconnect events and grants the FIFO to one connected source at a time, with message-granular round-robin. It aborts cleanly on disconnect or runaway messages. It sits between the per-host session engines and the TOE transmit FIFO.

## Interface
Parameters:
- `NUM_HOSTS`, 4: number of session sources / hosts.
- `HOST_W`, 2: host address width, equal to clog2(`NUM_HOSTS`).
- `DATA_W`, 8: byte width.
- `MAX_MSG_BYTES`, 1024: watchdog cap on the length of one message.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `connected_i` in 1: TOE connect event, one-cycle pulse.
- `connected_host_addr_i` in `HOST_W`: host for `connected_i`.
- `disconnect_i` in 1: TOE disconnect event, one-cycle pulse.
- `disconnect_host_num_i` in `HOST_W`: host for `disconnect_i`.
- `src_valid_i` in `NUM_HOSTS`: per-source byte valid.
- `src_last_i` in `NUM_HOSTS`: per-source last byte of message.
- `src_data_i` in `NUM_HOSTS*DATA_W`: per-source byte; source i occupies bits [i*8+:8].
- `src_ready_o` out `NUM_HOSTS`: per-source byte accepted this cycle.
- `fifo_full_i` in 1: TOE transmit FIFO full.
- `send_message_valid_o` out 1: byte write strobe to the FIFO.
- `message_o` out `DATA_W`: byte to the FIFO.
- `message_last_o` out 1: last byte of the message.
- `tx_host_o` out `HOST_W`: host owning the current byte.
- `host_up_o` out `NUM_HOSTS`: session table, one bit per connected host.
- `abort_o` out 1: one-cycle pulse when a message is truncated.

## Operation
Session table:
- `host_up[a]` is set on `connected_i` with address a.
- `host_up[a]` is cleared on `disconnect_i` with address a.
- If both events target the same host in the same cycle, the disconnect wins.
- Events that target different hosts in the same cycle both apply.

FSM states:
- IDLE: eligible = `src_valid_i & host_up`. If any source is eligible, pick the first eligible index at or after `rr_ptr`, wrapping modulo `NUM_HOSTS`. Latch it into `grant` and clear `byte_cnt`, then go to BUSY. If nothing is eligible, stay in IDLE.
- BUSY: `src_ready_o[grant]` = `!fifo_full_i && host_up[grant]`. All other bits of `src_ready_o` are 0. A transfer happens when `src_valid_i[grant]` and `src_ready_o[grant]` are both 1. Each transfer increments `byte_cnt`.
- BUSY to IDLE on a transfer with `src_last_i[grant]`. Set `rr_ptr` to `grant+1` (wraps).
- BUSY to IDLE when `host_up[grant]` drops, because a disconnect targeted `grant`. Pulse `abort_o` and set `rr_ptr` to `grant+1`. The remaining bytes of that message are not accepted. The source must flush them itself.
- Watchdog: when a transfer would make `byte_cnt` equal `MAX_MSG_BYTES` without last, the byte is forced out with `message_last_o`=1. Pulse `abort_o` and go to IDLE.
- `byte_cnt` is 11 bits wide and saturates; it never wraps.
- `fifo_full_i` stalls a transfer without changing state; BUSY holds its grant indefinitely.

## Timing
- Reset: every output is 0, `host_up`=0, `rr_ptr`=0, `grant`=0, state is IDLE.
- Reset asserted mid-message discards the message silently; `abort_o` stays 0.
- `host_up_o` updates 1 cycle after the connect/disconnect pulse.
- Arbitration takes 1 cycle. For a source eligible at cycle t in IDLE, `src_ready_o` can first be high at t+1.
- Output is registered. A transfer at cycle t produces `send_message_valid_o`, `message_o`, `message_last_o` and `tx_host_o` at t+1, each high or valid for exactly 1 cycle.
- Throughput is 1 byte/cycle within a message.
- There is exactly one IDLE cycle between messages, including back-to-back messages from the same source.
- `abort_o` is asserted in the cycle after the abort condition.
- `src_ready_o` is combinational from `fifo_full_i`, `state`, `grant` and `host_up`. Sources must not make `src_valid_i` depend on `src_ready_o`.

## Structure
- Package `fix_pkg`: `NUM_HOSTS`, `HOST_W`, `DATA_W`, `MAX_MSG_BYTES` constants, plus the `sched_state_t` enum {IDLE, BUSY}.
- Sub-module `fix_rr_picker`: combinational, taking `eligible[NUM_HOSTS]` and `rr_ptr`, producing `found` and `idx`. It is reused by the receive-side dispatcher.
- The top level holds the session table, the FSM, `byte_cnt` and the output register.

## Test plan
- Reset, then connect host 0 only. Source 0 sends 3 bytes 0x38,0x3D,0x46 (last on 0x46) while source 1 is valid but down. Expect 3 strobes to host 0 on consecutive cycles; `message_last_o` on 0x46 only; source 1 never ready.
- Hosts 0–3 up, all sources continuously valid with 2-byte messages. Expect `tx_host_o` order 0,1,2,3,0 with one gap cycle between messages.
- Host 2 mid-message, `fifo_full_i`=1 for 5 cycles. Expect no strobes and no `src_ready_o`; transfer resumes the cycle after full drops, with no bytes lost.
- Disconnect host 1 after 2 of 4 bytes. Expect `abort_o` pulse, `host_up_o`=4'b1101, no more host-1 bytes, next grant to host 2.
- Source 3 valid for 1024 bytes with no last. Expect byte 1024 to carry `message_last_o`=1, plus one `abort_o` pulse.
- Connect and disconnect host 0 in the same cycle. Expect `host_up_o[0]`=0. Assert `rst` mid-message: all outputs 0 on the next cycle.
